// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StPayload,
    StCsum,
    StDone,
    StError
  } state_e;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned CSUM_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream; word_valid pulses
// combinationally on the accept of each word's final byte.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q;
  logic [23:0] sreg_q;

  // Earlier bytes sit in the low lanes; the arriving byte completes the top lane.
  assign word       = {data, sreg_q};
  assign word_valid = accept && (cnt_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sreg_q <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
      sreg_q <= '0;
    end else if (accept) begin
      cnt_q  <= cnt_q + 2'd1;
      sreg_q <= {data, sreg_q[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: writes instruction memory from a checksummed byte stream and
// holds the core in reset until a verified image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  localparam int unsigned ADDR_W = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e state_q, state_d;

  logic              accept;
  logic              restart;
  logic              word_valid;
  logic [31:0]       word;
  logic [7:0]        hdr_lo_q;
  logic [15:0]       n_q;
  logic [15:0]       n_hdr;
  logic              hdr_bad;
  logic [15:0]       idx_q;
  logic              last_word;
  logic [CSUM_W-1:0] sum_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;

  assign accept    = in_valid && in_ready;
  assign restart   = start && (state_q == StIdle || state_q == StDone || state_q == StError);
  assign n_hdr     = {in_data, hdr_lo_q};
  assign hdr_bad   = (n_hdr == 16'd0) || (32'(n_hdr) > MEM_DEPTH);
  assign last_word = (idx_q == n_q - 16'd1);

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (restart),
    .accept     (accept && (state_q == StPayload)),
    .data       (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: if (start) state_d = StHdr0;
      StHdr0:    if (accept) state_d = StHdr1;
      StHdr1:    if (accept) state_d = hdr_bad ? StError : StPayload;
      StPayload: if (word_valid && last_word) state_d = StCsum;
      StCsum:    if (accept) state_d = (in_data == sum_q) ? StDone : StError;
      default:   state_d = StIdle;
    endcase
  end

  // State-decoded outputs; done/error/cpu_rst follow the registered state.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_rst  = 1'b1;
    unique case (state_q)
      StHdr0, StHdr1, StPayload, StCsum: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StDone: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
      end
      StError: error = 1'b1;
      default: ;
    endcase
  end

  // Datapath: header count, word index, running checksum, write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_lo_q <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      we_q <= word_valid;
      if (accept && state_q == StHdr0) hdr_lo_q <= in_data;
      if (accept && state_q == StHdr1) n_q <= n_hdr;
      if (restart) begin
        idx_q <= '0;
        sum_q <= '0;
      end else begin
        if (accept && state_q == StPayload) sum_q <= sum_q + in_data;
        if (word_valid) idx_q <= idx_q + 16'd1;
      end
      if (word_valid) begin
        waddr_q <= idx_q[ADDR_W-1:0];
        wdata_q <= word;
      end
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule
